// File: rtl/softmax_divider_block_if.sv
// softmax_divider_block_if: exponent/sum inputs and normalized-output handshake of the softmax divider.
interface softmax_divider_block_if #(parameter int data_size = 32);
    logic [data_size-1:0] exp_data_i;
    logic                 exp_data_valid_i;
    logic [data_size-1:0] sum_i;
    logic                 sum_valid_i;
    logic [data_size-1:0] div_data_o;
    logic                 div_valid_o;
    logic                 div_ready_i;
    logic                 done_o;
    logic                 overflow_o;
    modport slave (
        input  exp_data_i, exp_data_valid_i, sum_i, sum_valid_i, div_ready_i,
        output div_data_o, div_valid_o, done_o, overflow_o
    );
    modport master (
        output exp_data_i, exp_data_valid_i, sum_i, sum_valid_i, div_ready_i,
        input  div_data_o, div_valid_o, done_o, overflow_o
    );
endinterface

// File: rtl/softmax_divider_block.sv
// softmax_divider_block: buffers a frame of exponents, then divides each by the accumulated sum bit-serially.
module softmax_divider_block #(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int OUT_FRAC       = 16,
    parameter int SUM_SHIFT      = 4
) (
    input logic clock_i,
    input logic reset_n_i,
    softmax_divider_block_if.slave bus
);
    localparam int W  = data_size + OUT_FRAC;
    localparam int D  = data_size + SUM_SHIFT;
    localparam int CW = $clog2(number_of_data + 1);
    localparam int AW = number_of_data > 1 ? $clog2(number_of_data) : 1;
    localparam int SW = $clog2(W + 1);
    typedef enum logic [2:0] {COLLECT, LOAD, DIVIDE, OUTPUT, DONE} state_t;
    state_t state, state_n;
    logic [data_size-1:0] buffer [number_of_data];
    logic [CW-1:0] wr_cnt;
    logic [AW-1:0] rd_idx;
    logic [D-1:0]  divisor, rem, rem_nx;
    logic [W-1:0]  dvd;
    logic [W-2:0]  quo;
    logic [W-1:0]  quo_nx;
    logic [SW-1:0] step;
    logic [D:0]    rem_sh;
    logic sum_valid_q, start, wr, full, last, accept, ge;
    assign start  = bus.sum_valid_i & ~sum_valid_q;
    assign wr     = state == COLLECT && bus.exp_data_valid_i;
    assign full   = wr_cnt == CW'(number_of_data);
    assign last   = CW'(rd_idx) + CW'(1) == wr_cnt;
    assign accept = bus.div_valid_o & bus.div_ready_i;
    // Restoring step: a zero divisor always "fits", so the quotient saturates naturally.
    assign rem_sh = {rem, dvd[W-1]};
    assign ge     = rem_sh >= {1'b0, divisor};
    assign rem_nx = ge ? D'(rem_sh - {1'b0, divisor}) : rem_sh[D-1:0];
    assign quo_nx = {quo, ge};
    assign bus.div_valid_o = state == OUTPUT;
    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) state <= COLLECT;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            COLLECT: if (start) state_n = (wr_cnt == '0 && !wr) ? DONE : LOAD;
            LOAD:    state_n = DIVIDE;
            DIVIDE:  if (step == SW'(1)) state_n = OUTPUT;
            OUTPUT:  if (accept) state_n = last ? DONE : LOAD;
            DONE:    if (!bus.sum_valid_i) state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end
    always_ff @(posedge clock_i)
        if (wr && !full) buffer[wr_cnt[AW-1:0]] <= bus.exp_data_i;
    always_ff @(posedge clock_i or negedge reset_n_i)
        if (!reset_n_i) begin
            wr_cnt         <= '0;
            rd_idx         <= '0;
            bus.div_data_o <= '0;
            bus.done_o     <= 1'b0;
            bus.overflow_o <= 1'b0;
            sum_valid_q    <= 1'b0;
            divisor        <= '0;
            rem            <= '0;
            dvd            <= '0;
            quo            <= '0;
            step           <= '0;
        end else begin
            sum_valid_q <= bus.sum_valid_i;
            bus.done_o  <= state_n == DONE && state != DONE;
            if (wr && full) bus.overflow_o <= 1'b1;
            if (wr && !full) wr_cnt <= wr_cnt + CW'(1);
            if (state == COLLECT && start) begin
                divisor <= {bus.sum_i, {SUM_SHIFT{1'b0}}};
                rd_idx  <= '0;
            end
            if (state == LOAD) begin
                dvd  <= {buffer[rd_idx], {OUT_FRAC{1'b0}}};
                rem  <= '0;
                quo  <= '0;
                step <= SW'(W);
            end
            if (state == DIVIDE) begin
                dvd  <= dvd << 1;
                rem  <= rem_nx;
                quo  <= quo_nx[W-2:0];
                step <= step - SW'(1);
                if (step == SW'(1)) bus.div_data_o <= |quo_nx[W-1:data_size] ? '1 : quo_nx[data_size-1:0];
            end
            if (accept && !last) rd_idx <= rd_idx + AW'(1);
            if (state == DONE && !bus.sum_valid_i) wr_cnt <= '0;
        end
endmodule

// File: doc/softmax_divider_block.md
# softmax_divider_block

Final softmax stage, directly downstream of the exponent-sum accumulator. It buffers each exponent value as it streams in alongside the accumulator input. Once the accumulated sum is valid, it divides every buffered exponent by the sum with a bit-serial restoring divider. Normalized outputs are emitted one at a time over a valid/ready handshake, followed by a done pulse.

## Interface
- data_size, 32, width of exponent values, sum and outputs
- number_of_data, 10, buffer depth (elements per softmax frame)
- OUT_FRAC, 16, fractional bits of the output quotient
- SUM_SHIFT, 4, left shift restoring the accumulator's pre-scaled sum (sum_i represents true_sum >> 4)

Ports:
- clock_i  in  1  single clock, rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- exp_data_i  in  data_size  exponent value (same stream that feeds the accumulator)
- exp_data_valid_i  in  1  exp_data_i write strobe
- sum_i  in  data_size  accumulator sum output
- sum_valid_i  in  1  accumulator valid (level; stays high until the accumulator is reset)
- div_data_o  out  data_size  quotient for current element
- div_valid_o  out  1  div_data_o valid
- div_ready_i  in  1  consumer ready
- done_o  out  1  one-cycle pulse after the last element is accepted
- overflow_o  out  1  sticky: a write arrived while the buffer was full

## Operation
- Buffer: number_of_data × data_size registers, plus write pointer/count wr_cnt (0..number_of_data).
  - In COLLECT, each exp_data_valid_i writes buffer[wr_cnt] and increments wr_cnt.
  - A write when wr_cnt == number_of_data is dropped and sets overflow_o.
- Start: rising edge of sum_valid_i, detected via a registered copy, while in COLLECT. On start, latch divisor = {sum_i, SUM_SHIFT zeros} (data_size+SUM_SHIFT bits) and clear rd_idx.
- Per element: dividend = {buffer[rd_idx], OUT_FRAC zeros} (data_size+OUT_FRAC bits).
  - One restoring step per cycle, MSB first: remainder = {remainder, next dividend bit}. If remainder ≥ divisor, subtract and shift 1 into the quotient, else shift 0.
  - Quotient = floor((e << OUT_FRAC) / (sum_i << SUM_SHIFT)).
  - If the quotient exceeds data_size bits, saturate to all ones.
  - If divisor == 0, output all ones with no error flag.
- States:
  - COLLECT: accept writes; on start → LOAD, or → DONE if wr_cnt == 0.
  - LOAD: fetch buffer[rd_idx], clear remainder/quotient, step counter = data_size+OUT_FRAC → DIVIDE.
  - DIVIDE: one iteration per cycle; on the final iteration → OUTPUT.
  - OUTPUT: div_valid_o = 1. On div_valid_o & div_ready_i: if rd_idx == wr_cnt−1 → DONE, else rd_idx++ → LOAD.
  - DONE: done_o pulses on entry only. When sum_valid_i == 0: clear wr_cnt → COLLECT. overflow_o is cleared only by reset.
- exp_data_valid_i outside COLLECT is ignored and does not set overflow_o.
- A frame with fewer than number_of_data writes processes only wr_cnt elements.

## Timing
- Reset values (asynchronous, take effect immediately): state COLLECT; wr_cnt, rd_idx, div_data_o, div_valid_o, done_o and overflow_o all 0. Buffer contents are don't-care.
- Reset mid-division aborts immediately with no output; the next frame starts clean.
- Start sampled at edge T: LOAD at T+1, DIVIDE T+2..T+1+(data_size+OUT_FRAC), div_valid_o high from T+2+(data_size+OUT_FRAC). With defaults this is T+50.
- Accept at edge A: div_valid_o low from A+1, LOAD at A+1, next valid at A+1+1+48. Minimum 50 cycles per element with defaults.
- div_data_o is stable while div_valid_o is high and div_ready_i is low.
- done_o is high for exactly the one cycle after the final accept.
- A write in the same cycle as start: the write is stored and counted, and that element is processed.

## Test plan
- N=4, writes 0x10 ×4, sum_i=0x4 then sum_valid_i rises, ready=1: four outputs of 0x00004000; first valid 50 cycles after start; done_o pulses once.
- N=2, writes 0x30, 0x10, sum_i=0x4: outputs 0x0000C000 then 0x00004000 in write order.
- Backpressure: hold div_ready_i=0 for 10 cycles during OUTPUT: div_valid_o and div_data_o held constant; no skipped or duplicated element.
- sum_i=0 with writes 0x5, 0x7: both outputs 0xFFFFFFFF.
- Short frame and overflow:
  - N=4 with 2 writes: exactly 2 outputs, then done_o.
  - Separate frame with 5 writes: overflow_o=1; 4 outputs, the 5th value discarded.
- Reset pulse during DIVIDE of element 1: all outputs 0 at once. A following frame (0x10 ×4, sum 0x4) yields 0x00004000 ×4.
